// File: rtl/hp_au_pkg.sv
// Shared HP-AU definitions: divider FSM state encoding and the select
// codes reserved for routing divider results into the HP-AU output mux.
package hp_au_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Future HP-AU result select codes for the divider outputs.
  localparam logic [3:0] SEL_DIV = 4'd8;
  localparam logic [3:0] SEL_REM = 4'd9;

endpackage

// File: rtl/hp_au_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference if it fits.
module hp_au_div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, dvd_msb};
  assign trial   = shifted - {1'b0, dvs};

  // A clear top bit means the subtraction did not borrow, so the divisor fits.
  assign q_bit = ~trial[WIDTH];

  // When the divisor does not fit, shifted < dvs, so its low WIDTH bits hold it exactly.
  assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/hp_au_seq_divider.sv
// Sequential restoring divider: unsigned a / b and a % b, one quotient bit per
// clock, behind a start/busy/done handshake. Divide-by-zero finishes in one cycle.
module hp_au_seq_divider
  import hp_au_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH-1:0] next_rem;
  logic             q_bit;

  hp_au_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .dvs      (dvs_q),
    .next_rem (next_rem),
    .q_bit    (q_bit)
  );

  // FSM plus datapath: accept a request in IDLE, iterate in CALC, pulse DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here is a small flop, so all are reset; an in-flight op is simply dropped.
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every read below sees the pre-edge register value.
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dvd_q <= a;
            dvs_q <= b;
            rem_q <= '0;
            cnt_q <= CW'(WIDTH - 1);
            if (b == '0) begin
              quotient_q  <= '1;
              remainder_q <= a;
              dbz_q       <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              dbz_q   <= 1'b0;
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_q <= next_rem;
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
          if (cnt_q == '0) begin
            quotient_q  <= {dvd_q[WIDTH-2:0], q_bit};
            remainder_q <= next_rem;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hp_au_seq_divider.sv
// Self-checking bench for hp_au_seq_divider (WIDTH=4): directed cases, a
// mid-operation reset, an ignored start, an exhaustive sweep and random ops,
// all checked against plain-arithmetic expectations.
module tb_hp_au_seq_divider;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int total = 0;
  int bad   = 0;

  hp_au_seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one operation at the current negedge and follow it to completion.
  // inject_at > 0 pulses a competing start (9/4) at that cycle of the operation.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input int inject_at, input string tag);
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_r;
    logic             exp_dbz;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_r;
    int               lat;
    int               exp_lat;
    prev_q = quotient;
    prev_r = remainder;
    check({tag, "_idle_before"}, 32'(busy), 32'd0);
    if (tb_v == 0) begin
      exp_q   = '1;
      exp_r   = ta;
      exp_dbz = 1'b1;
      exp_lat = 1;
    end else begin
      exp_q   = ta / tb_v;
      exp_r   = ta % tb_v;
      exp_dbz = 1'b0;
      exp_lat = WIDTH + 1;
    end
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    lat   = 1;
    while (!done && lat < 20) begin
      check({tag, "_busy_calc"}, 32'(busy), 32'd1);
      check({tag, "_q_hold"}, 32'(quotient), 32'(prev_q));
      check({tag, "_r_hold"}, 32'(remainder), 32'(prev_r));
      if (lat == inject_at) begin
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_q"}, 32'(quotient), 32'(exp_q));
    check({tag, "_r"}, 32'(remainder), 32'(exp_r));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_q_keep"}, 32'(quotient), 32'(exp_q));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, issued back to back at the minimum interval.
    run_op(4'd13, 4'd3, 0, "d13_3");
    run_op(4'd7, 4'd0, 0, "d7_0");
    run_op(4'd6, 4'd2, 0, "d6_2");
    run_op(4'd15, 4'd1, 0, "d15_1");
    run_op(4'd2, 4'd9, 0, "d2_9");
    run_op(4'd0, 4'd5, 0, "d0_5");
    run_op(4'd15, 4'd15, 0, "d15_15");

    // A start pulsed during CALC must be dropped, not queued.
    run_op(4'd13, 4'd3, 2, "ign");
    repeat (3) begin
      @(negedge clk);
      check("ign_no_second_done", 32'(done), 32'd0);
      check("ign_no_second_busy", 32'(busy), 32'd0);
    end

    // Asynchronous reset in the middle of an operation.
    a     = 4'd13;
    b     = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_q", 32'(quotient), 32'd0);
    check("mid_rst_r", 32'(remainder), 32'd0);
    check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(4'd9, 4'd4, 0, "post_rst");

    // Exhaustive sweep with the division identity checked on every non-zero divisor.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_op(WIDTH'(ia), WIDTH'(ib), 0, "sweep");
        if (ib != 0) begin
          check("sweep_identity", 32'(quotient) * 32'(ib) + 32'(remainder), 32'(ia));
          check("sweep_r_lt_b", 32'(remainder < WIDTH'(ib)), 32'd1);
        end
      end
    end

    // Random operations.
    for (int n = 0; n < 40; n++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom_range(0, 15)), 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Protocol invariant: done never appears without busy.
  always @(negedge clk) begin
    if (rst_n) begin
      check("done_implies_busy", 32'(done & ~busy), 32'd0);
    end
  end

endmodule
